// File: rtl/fpu_adder_pipe.sv
// fpu_adder_pipe: 3-stage floating-point add/subtract with round-to-nearest-even.
// Denormals flush to zero; a valid/ready handshake stalls all stages together.
module fpu_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [15:0] SHMAX = 16'(MAN_W + 3);
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic v1_q, v2_q, v3_q;

  assign in_ready  = !v3_q || out_ready;
  assign en        = in_ready;
  assign out_valid = v3_q;

  // ---------------- S1: unpack, classify, swap, align
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, ebig, esml;
  logic [MAN_W-1:0] ma, mb, fa, fb;
  logic             za, zb, ia, ib, na, nb, a_big;
  logic [SW-1:0]    xa, xb, big_d, sml_in, sml_d, mask;
  logic [15:0]      d, sh;
  logic             sign1_d, esub1_d, spec1_d, sinv1_d;
  logic [W-1:0]     sres1_d;

  // Classify operands, order by magnitude and align the smaller one
  always_comb begin
    sa = a[W-1];
    sb = b[W-1] ^ sub;
    ea = a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    ma = a[MAN_W-1:0];
    mb = b[MAN_W-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    ia = (ea == EMAX) && (ma == '0);
    ib = (eb == EMAX) && (mb == '0);
    na = (ea == EMAX) && (ma != '0);
    nb = (eb == EMAX) && (mb != '0);
    fa = za ? '0 : ma;
    fb = zb ? '0 : mb;
    xa = za ? '0 : {1'b1, ma, 3'b000};
    xb = zb ? '0 : {1'b1, mb, 3'b000};
    a_big = ({ea, fa} >= {eb, fb});
    big_d  = a_big ? xa : xb;
    sml_in = a_big ? xb : xa;
    ebig   = a_big ? ea : eb;
    esml   = a_big ? eb : ea;
    sign1_d = a_big ? sa : sb;
    esub1_d = sa ^ sb;
    d  = 16'(ebig) - 16'(esml);
    sh = (d > SHMAX) ? SHMAX : d;
    mask  = ~({SW{1'b1}} << sh);
    sml_d = sml_in >> sh;
    sml_d[0] = sml_d[0] | (|(sml_in & mask));
    spec1_d = 1'b0;
    sinv1_d = 1'b0;
    sres1_d = '0;
    if (na || nb || (ia && ib && (sa != sb))) begin
      spec1_d = 1'b1;
      sinv1_d = 1'b1;
      sres1_d = QNAN;
    end else if (ia) begin
      spec1_d = 1'b1;
      sres1_d = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (ib) begin
      spec1_d = 1'b1;
      sres1_d = {sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  logic             sign1_q, esub1_q, spec1_q, sinv1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [SW-1:0]    big1_q, sml1_q;
  logic [W-1:0]     sres1_q;

  // Stage valid bits advance together; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // S1 payload register
  always_ff @(posedge clk) begin
    if (en) begin
      sign1_q <= sign1_d;
      esub1_q <= esub1_d;
      spec1_q <= spec1_d;
      sinv1_q <= sinv1_d;
      sres1_q <= sres1_d;
      exp1_q  <= ebig;
      big1_q  <= big_d;
      sml1_q  <= sml_d;
    end
  end

  // ---------------- S2: magnitude add/subtract
  logic [SW:0]      sum2_d, sum2_q;
  logic             sign2_q, esub2_q, spec2_q, sinv2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [W-1:0]     sres2_q;

  // Larger magnitude is always big1_q, so the difference never wraps
  always_comb begin
    if (esub1_q) sum2_d = {1'b0, big1_q} - {1'b0, sml1_q};
    else         sum2_d = {1'b0, big1_q} + {1'b0, sml1_q};
  end

  // S2 payload register
  always_ff @(posedge clk) begin
    if (en) begin
      sum2_q  <= sum2_d;
      sign2_q <= sign1_q;
      esub2_q <= esub1_q;
      spec2_q <= spec1_q;
      sinv2_q <= sinv1_q;
      sres2_q <= sres1_q;
      exp2_q  <= exp1_q;
    end
  end

  // ---------------- S3: normalise, round, pack, flag
  int                 msb;
  logic               nz, rup;
  logic [15:0]        lsh;
  logic [SW-1:0]      norm;
  logic [MAN_W+1:0]   mant;
  logic [MAN_W-1:0]   frac;
  logic signed [15:0] e_n, e_r;
  logic [W-1:0]       res_d;
  logic               ovf_d, unf_d, inv_d;

  // Normalise the sum, round to nearest even and resolve special cases
  always_comb begin
    msb = 0;
    for (int i = 0; i < SW; i++) begin
      if (sum2_q[i]) msb = i;
    end
    nz  = |sum2_q;
    lsh = 16'(SW - 1 - msb);
    if (sum2_q[SW]) begin
      norm = sum2_q[SW:1];
      norm[0] = sum2_q[1] | sum2_q[0];
      e_n = $signed(16'(exp2_q)) + 16'sd1;
    end else begin
      norm = sum2_q[SW-1:0] << lsh;
      e_n = $signed(16'(exp2_q)) - $signed(lsh);
    end
    rup  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    e_r  = mant[MAN_W+1] ? e_n + 16'sd1 : e_n;
    frac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (spec2_q) begin
      res_d = sres2_q;
      inv_d = sinv2_q;
    end else if (!nz) begin
      res_d = {sign2_q & ~esub2_q, {(W-1){1'b0}}};
    end else if (e_r >= $signed(16'(EMAX))) begin
      ovf_d = 1'b1;
      res_d = {sign2_q, EMAX, {MAN_W{1'b0}}};
    end else if (e_r <= 16'sd0) begin
      unf_d = 1'b1;
      res_d = {sign2_q, {(W-1){1'b0}}};
    end else begin
      res_d = {sign2_q, e_r[EXP_W-1:0], frac};
    end
  end

  logic [W-1:0] res_q;
  logic         ovf_q, unf_q, inv_q;

  // Output register: cleared on reset, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (en) begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
    end
  end

  assign result    = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: doc/fpu_adder_pipe.md
FPU_ADDER_PIPE -- requirements
Module: fpu_adder_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa field width (range 4..52); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands a, b and sub are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754-style {sign, exp, man}.
REQ-008 SHALL have port b  input  W  operand B, same format.
REQ-009 SHALL have port sub  input  1  0 = a+b; 1 = a-b (sign of b inverted).
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port result  output  W  rounded sum.
REQ-013 SHALL have port overflow  output  1  result rounded to +/-infinity from finite operands.
REQ-014 SHALL have port underflow  output  1  nonzero exact result flushed to zero.
REQ-015 SHALL have port invalid  output  1  result is NaN from NaN input or inf-inf.

Function
REQ-016 SHALL implement a 3-stage pipeline: S1 unpack, classify, swap, align with guard/round/sticky; S2 add/subtract magnitudes; S3 normalise, round, pack, flag.
REQ-017 SHALL have latency exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid with no backpressure.
REQ-018 SHALL sustain one result per cycle while out_ready is held 1.
REQ-019 SHALL drive in_ready = !out_valid | out_ready; on in_ready = 0 all stages hold their contents.
REQ-020 SHALL hold result and flags stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL propagate bubbles: when in_ready = 1 and in_valid = 0, an invalid slot enters S1.
REQ-022 SHALL never drop or duplicate a result; at most 3 results are in flight.
REQ-023 SHALL round to nearest, ties to even, using guard, round and sticky bits.
REQ-024 SHALL treat inputs with exp = 0 as signed zero (flush denormals).
REQ-025 SHALL flush a result with biased exp <= 0 after rounding to signed zero and set underflow = 1 if the exact result is nonzero.
REQ-026 SHALL output signed infinity with overflow = 1 when the rounded exp >= 2^EXP_W-1 and both operands are finite.
REQ-027 SHALL output canonical qNaN {0, all-ones exp, MSB man = 1, rest 0} and invalid = 1 for any NaN input or for infinities of opposite effective sign.
REQ-028 SHALL output infinity with that sign, and all flags 0, when exactly one operand is infinite, or both are infinite with the same effective sign.
REQ-029 SHALL output +0 for an exact-zero sum of opposite signs; (-0)+(-0) SHALL give -0.
REQ-030 SHALL right-shift alignment saturate at MAN_W+3, with all shifted-out bits folded into sticky.

Reset
REQ-031 SHALL, on rst = 1 at a clock edge, clear all stage valid bits, regardless of backpressure or in-flight data.
REQ-032 SHALL, on rst = 1 at a clock edge, set out_valid, result, overflow, underflow and invalid to 0.
REQ-033 SHALL drive in_ready = 1 during and after reset, because out_valid = 0.
REQ-034 SHALL produce, after reset is released, no out_valid for any operand set accepted before or during reset.

Verification
REQ-035 SHALL check defaults, out_ready = 1: a = 0x3F800000, b = 0x40000000, sub = 0 -> result 0x40400000 exactly 3 cycles later, flags 0.
REQ-036 SHALL check rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800001 + 0x33800000 -> 0x3F800002.
REQ-037 SHALL check cancellation and specials: 0x3F800000 - 0x3F800000 -> 0x00000000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow = 1; 0x7F800000 + 0xFF800000 -> 0x7FC00000 with invalid = 1.
REQ-038 SHALL check backpressure: out_ready = 0 while in_valid = 1 for 6 cycles -> exactly 3 accepted, in_ready = 0 afterwards; release -> 3 results in order, none lost.
REQ-039 SHALL check reset mid-stream: rst = 1 for one cycle with 3 in flight -> out_valid = 0 next cycle and no stale results afterwards.
REQ-040 SHALL check EXP_W = 5, MAN_W = 10: 0x3C00 + 0x3C00 -> 0x4000, and randomised sums against a reference model, bit-exact including flags.
